// File: rtl/wasm_instr_loader.sv
// Framed byte-stream loader: checks magic/length/XOR checksum and packs payload
// bytes little-endian into variable-length writes to the instruction memory.
module wasm_instr_loader #(
  parameter int          WRITE_BYTES     = 4,
  parameter int          LOG_WRITE_BYTES = 2,
  parameter logic [15:0] MAX_LEN         = 16'd4096
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_byte_vld,
  input  logic [7:0]                 i_byte,
  output logic                       o_byte_rdy,
  output logic                       o_we,
  output logic [LOG_WRITE_BYTES-1:0] o_write_pointer_shift_minusone,
  output logic [8*WRITE_BYTES-1:0]   o_wr_data,
  input  logic                       i_wr_full,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [1:0]                 o_error
);

  localparam int DW = 8 * WRITE_BYTES;
  localparam int CW = LOG_WRITE_BYTES + 1;
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                     state;
  logic [7:0]                 len_lo;
  logic [15:0]                remaining;
  logic [CW-1:0]              cnt;
  logic [DW-1:0]              pack;
  logic [7:0]                 chk_xor;
  logic                       we_q;
  logic [LOG_WRITE_BYTES-1:0] shift_q;
  logic [DW-1:0]              wr_data_q;
  logic                       done_q;
  logic [1:0]                 error_q;

  function automatic logic [DW-1:0] insert_lane(input logic [DW-1:0] word,
                                                input logic [CW-1:0] lane,
                                                input logic [7:0]    b);
    logic [DW-1:0] r;
    r = word;
    for (int i = 0; i < WRITE_BYTES; i++) begin
      if (lane == CW'(i)) r[8*i +: 8] = b;
    end
    return r;
  endfunction

  logic          xfer;
  logic          wr_done;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] pack_nxt;
  logic [15:0]   len_full;
  logic          last_byte;

  assign xfer      = i_byte_vld && o_byte_rdy;
  assign wr_done   = we_q && !i_wr_full;
  assign cnt_nxt   = cnt + CW'(1);
  assign pack_nxt  = insert_lane(pack, cnt, i_byte);
  assign len_full  = {i_byte, len_lo};
  assign last_byte = (remaining == 16'd1);

  // Input is stalled while a word is held for the memory, so packing never
  // overlaps a pending write.
  assign o_byte_rdy = !we_q && (state != S_DONE);
  assign o_busy     = (state != S_IDLE);
  assign o_we       = we_q;
  assign o_write_pointer_shift_minusone = shift_q;
  assign o_wr_data  = wr_data_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      len_lo    <= '0;
      remaining <= '0;
      cnt       <= '0;
      pack      <= '0;
      chk_xor   <= '0;
      we_q      <= 1'b0;
      shift_q   <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 2'b00;
    end else begin
      done_q <= 1'b0;
      if (wr_done) begin
        we_q <= 1'b0;
        cnt  <= '0;
        pack <= '0;
      end
      case (state)
        S_IDLE: begin
          if (xfer && i_byte == MAGIC) begin
            state   <= S_LEN_LO;
            error_q <= 2'b00;
            chk_xor <= '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= i_byte;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            if (len_full > MAX_LEN) begin
              error_q <= 2'b10;
              state   <= S_IDLE;
            end else if (len_full == 16'd0) begin
              state <= S_CHECK;
            end else begin
              remaining <= len_full;
              state     <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            pack      <= pack_nxt;
            cnt       <= cnt_nxt;
            chk_xor   <= chk_xor ^ i_byte;
            remaining <= remaining - 16'd1;
            // Shift is cnt_nxt-1, which is simply the lane just written.
            if (cnt_nxt == CW'(WRITE_BYTES) || last_byte) begin
              we_q      <= 1'b1;
              shift_q   <= cnt[LOG_WRITE_BYTES-1:0];
              wr_data_q <= pack_nxt;
            end
            if (last_byte) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (i_byte != chk_xor) error_q <= 2'b01;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Directed bench for wasm_instr_loader: framed loads, checksum/length errors,
// write back-pressure and mid-frame reset.
module tb_wasm_instr_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_byte_vld = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_byte_rdy;
  logic        o_we;
  logic [1:0]  o_write_pointer_shift_minusone;
  logic [31:0] o_wr_data;
  logic        i_wr_full = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_error;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [31:0] wq_data[$];
  logic [1:0]  wq_shift[$];

  wasm_instr_loader #(
    .WRITE_BYTES(4),
    .LOG_WRITE_BYTES(2),
    .MAX_LEN(16'd4096)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_byte_vld(i_byte_vld),
    .i_byte(i_byte),
    .o_byte_rdy(o_byte_rdy),
    .o_we(o_we),
    .o_write_pointer_shift_minusone(o_write_pointer_shift_minusone),
    .o_wr_data(o_wr_data),
    .i_wr_full(i_wr_full),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // Completed writes and done pulses, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (i_rst_n && o_we && !i_wr_full) begin
      wq_data.push_back(o_wr_data);
      wq_shift.push_back(o_write_pointer_shift_minusone);
    end
    if (i_rst_n && o_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_shift);
    tests++;
    if (wq_data.size() == 0) begin
      fails++;
      $error("FAIL %s observed=no_write expected=%0h/%0h", tag, exp_data, exp_shift);
    end else begin
      logic [31:0] d;
      logic [1:0]  s;
      d = wq_data.pop_front();
      s = wq_shift.pop_front();
      assert (d === exp_data && s === exp_shift) else begin
        fails++;
        $error("FAIL %s observed=%0h/%0h expected=%0h/%0h", tag, d, s, exp_data, exp_shift);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte_vld = 1'b1;
    i_byte = b;
    while (!o_byte_rdy && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $error("FAIL rdy_timeout observed=rdy0 expected=rdy1 byte=%0h", b);
    end
    @(posedge i_clk); #1;
    i_byte_vld = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  initial begin
    int d0;
    // Reset
    tick(); tick();
    check("rst_rdy", o_byte_rdy, 1);
    check("rst_we", o_we, 0);
    check("rst_shift", o_write_pointer_shift_minusone, 0);
    check("rst_data", o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_error, 0);
    i_rst_n = 1'b1;
    tick();

    // Frame 1: 8 bytes, two full words
    send_byte(8'hA5); send_byte(8'h08); send_byte(8'h00);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    check("f1_we_latency", o_we, 1);
    check("f1_rdy_held", o_byte_rdy, 0);
    check("f1_data_w0", o_wr_data, 32'h04030201);
    tick();
    check("f1_rdy_back", o_byte_rdy, 1);
    check("f1_we_drop", o_we, 0);
    for (int i = 5; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h08);
    check("f1_done_pulse", o_done, 1);
    check("f1_busy_done", o_busy, 1);
    tick();
    check("f1_done_clear", o_done, 0);
    check("f1_busy_idle", o_busy, 0);
    check("f1_err", o_error, 0);
    check("f1_done_cnt", done_cnt, 1);
    check("f1_wr_cnt", wq_data.size(), 2);
    check_wr("f1_w0", 32'h04030201, 2'd3);
    check_wr("f1_w1", 32'h08070605, 2'd3);

    // Frame 2: 5 bytes, partial last word
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    check("f2_check_we", o_we, 1);
    check("f2_check_rdy", o_byte_rdy, 0);
    check("f2_check_busy", o_busy, 1);
    send_byte(8'h11);
    tick();
    check("f2_err", o_error, 0);
    check("f2_done_cnt", done_cnt, 2);
    check_wr("f2_w0", 32'h44332211, 2'd3);
    check_wr("f2_w1", 32'h00000055, 2'd0);

    // Frame 3: bad checksum, sticky error
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h00);
    check("f3_err_done", o_error, 2'b01);
    tick(); tick(); tick();
    check("f3_err_sticky", o_error, 2'b01);
    check("f3_done_cnt", done_cnt, 3);
    check_wr("f3_w0", 32'h44332211, 2'd3);
    check_wr("f3_w1", 32'h00000055, 2'd0);
    send_byte(8'hA5);
    check("f3_err_cleared", o_error, 2'b00);

    // Length 0x1001 rejected, following bytes discarded
    send_byte(8'h01); send_byte(8'h10);
    check("len_err", o_error, 2'b10);
    check("len_busy", o_busy, 0);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h11);
    tick();
    check("len_discard_busy", o_busy, 0);
    check("len_no_we", wq_data.size(), 0);
    check("len_no_done", done_cnt, 3);
    check("len_err_sticky", o_error, 2'b10);

    // 0xA5 inside payload is data; 2-byte write
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h00);
    tick();
    check("a5_err", o_error, 0);
    check("a5_done_cnt", done_cnt, 4);
    check_wr("a5_w0", 32'h0000A5A5, 2'd1);

    // Zero-length frame
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    check("zero_busy", o_busy, 1);
    send_byte(8'h00);
    tick();
    check("zero_done_cnt", done_cnt, 5);
    check("zero_no_wr", wq_data.size(), 0);
    check("zero_err", o_error, 0);

    // Length exactly MAX_LEN
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    check("max_busy", o_busy, 1);
    for (int i = 0; i < 4096; i++) send_byte(i[7:0]);
    send_byte(8'h00);
    tick();
    check("max_err", o_error, 0);
    check("max_done_cnt", done_cnt, 6);
    check("max_wr_cnt", wq_data.size(), 1024);
    if (wq_data.size() == 1024) begin
      check("max_last_data", wq_data[1023], 32'hFFFEFDFC);
      check("max_first_data", wq_data[0], 32'h03020100);
    end
    wq_data.delete();
    wq_shift.delete();

    // Back-pressure on first word
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    i_wr_full = 1'b1;
    send_byte(8'hEF);
    for (int i = 0; i < 5; i++) begin
      check("stall_we", o_we, 1);
      check("stall_data", o_wr_data, 32'hEFBEADDE);
      check("stall_shift", o_write_pointer_shift_minusone, 2'd3);
      check("stall_rdy", o_byte_rdy, 0);
      tick();
    end
    check("stall_no_wr", wq_data.size(), 0);
    i_wr_full = 1'b0;
    tick();
    check("stall_we_drop", o_we, 0);
    check("stall_rdy_back", o_byte_rdy, 1);
    d0 = done_cnt;
    send_byte(8'h22);
    tick();
    check("stall_err", o_error, 0);
    check("stall_done", done_cnt, d0 + 1);
    check_wr("stall_w0", 32'hEFBEADDE, 2'd3);

    // Reset mid-frame, then a clean frame
    send_byte(8'hA5); send_byte(8'h08); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    i_rst_n = 1'b0;
    tick();
    check("mrst_rdy", o_byte_rdy, 1);
    check("mrst_we", o_we, 0);
    check("mrst_shift", o_write_pointer_shift_minusone, 0);
    check("mrst_data", o_wr_data, 0);
    check("mrst_busy", o_busy, 0);
    check("mrst_done", o_done, 0);
    check("mrst_err", o_error, 0);
    i_rst_n = 1'b1;
    tick();
    d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    send_byte(8'h00);
    tick();
    check("post_err", o_error, 0);
    check("post_done", done_cnt, d0 + 1);
    check("post_wr_cnt", wq_data.size(), 1);
    check_wr("post_w0", 32'h0D0C0B0A, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
